// File: rtl/johnson_seq_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : johnson_seq_monitor
//  Purpose  : Samples a Johnson (twisted-ring) counter on a qualifier strobe,
//             decodes it to a phase index and a one-hot phase strobe, and
//             checks that successive samples follow the legal sequence.
//             It locks after a run of good transitions and flags and counts
//             sequence errors with a saturating counter.
//  Options  : JOHNSON_MON_HOLD_EN - when defined, a sample that repeats the
//             reference phase (a counter stall) is treated as a no-op while
//             tracking, instead of as a wrong code.
//  Revision : 1.0 - initial release
// ============================================================================
module johnson_seq_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_en,
  input  logic [WIDTH-1:0]              count_in,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic                          phase_valid,
  output logic [2*WIDTH-1:0]            phase_strobe,
  output logic                          locked,
  output logic                          err_pulse,
  output logic [ERR_CNT_W-1:0]          err_count
);

  localparam int c_NPH = 2 * WIDTH;
  localparam int c_PW  = $clog2(c_NPH);
  localparam int c_GW  = $clog2(c_NPH + 1);
  localparam logic [c_GW-1:0]  c_LOCK = c_GW'(LOCK_COUNT);
  localparam logic [c_PW-1:0]  c_LAST = c_PW'(c_NPH - 1);
  localparam logic [c_NPH-1:0] c_ONE  = c_NPH'(1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_CHECK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_GW-1:0]   r_good_cnt;
  logic [c_PW-1:0]   r_phase;
  logic              r_phase_valid;
  logic [c_NPH-1:0]  r_strobe;
  logic              r_locked;
  logic              r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic              w_legal;
  logic [c_PW-1:0]   w_dec;
  logic [c_PW-1:0]   w_exp;
  logic              w_hold;

  // Canonical code for phase p: fill ones from the LSB for the first half,
  // then clear ones from the LSB for the second half.
  function automatic logic [WIDTH-1:0] f_code(input int p);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (p <= WIDTH) v[b] = (b < p);
      else            v[b] = (b >= (p - WIDTH));
    end
    return v;
  endfunction

  // Decode the incoming code against every legal phase.
  always_comb begin
    w_legal = 1'b0;
    w_dec   = '0;
    for (int p = 0; p < c_NPH; p++) begin
      if (count_in == f_code(p)) begin
        w_legal = 1'b1;
        w_dec   = c_PW'(p);
      end
    end
  end

  // The last legal phase doubles as the tracking reference: every legal
  // sample updates both, and an illegal one drops tracking back to SEARCH.
  assign w_exp = (r_phase == c_LAST) ? '0 : r_phase + 1'b1;

`ifdef JOHNSON_MON_HOLD_EN
  assign w_hold = w_legal && (w_dec == r_phase) && (r_state != S_SEARCH);
`else
  assign w_hold = 1'b0;
`endif

  // Tracking FSM with registered decode, lock and error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_SEARCH;
      r_good_cnt    <= '0;
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_strobe      <= '0;
      r_locked      <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_strobe    <= '0;
      r_err_pulse <= 1'b0;
      if (sample_en) begin
        if (w_legal) begin
          r_phase       <= w_dec;
          r_phase_valid <= 1'b1;
          r_strobe      <= c_ONE << w_dec;
        end else begin
          r_phase_valid <= 1'b0;
        end
        case (r_state)
          S_SEARCH: begin
            if (w_legal) begin
              r_good_cnt <= '0;
              r_state    <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (!w_legal) begin
              r_state <= S_SEARCH;
            end else if (w_hold) begin
              r_state <= S_CHECK;
            end else if (w_dec == w_exp) begin
              r_good_cnt <= r_good_cnt + 1'b1;
              if ((r_good_cnt + 1'b1) == c_LOCK) begin
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_good_cnt <= '0;
            end
          end
          S_LOCKED: begin
            if (!(w_hold || (w_legal && (w_dec == w_exp)))) begin
              r_err_pulse <= 1'b1;
              r_locked    <= 1'b0;
              r_good_cnt  <= '0;
              if (r_err_count != {ERR_CNT_W{1'b1}})
                r_err_count <= r_err_count + 1'b1;
              r_state <= w_legal ? S_CHECK : S_SEARCH;
            end
          end
          default: r_state <= S_SEARCH;
        endcase
      end
    end
  end

  assign phase        = r_phase;
  assign phase_valid  = r_phase_valid;
  assign phase_strobe = r_strobe;
  assign locked       = r_locked;
  assign err_pulse    = r_err_pulse;
  assign err_count    = r_err_count;

endmodule
`default_nettype wire
